// File: rtl/avst_word_sink.sv
// Avalon-ST byte sink that packs 4-byte packets into MSB-first 32-bit words.
// Define AVST_WORD_SINK_LEN_CHECK_EN to reject packets whose length is not 4 bytes.
module avst_word_sink #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       data_in,
    input  logic             end_in,
    input  logic             valid_in,
    output logic             ready_in,
    output logic [31:0]      word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             len_err,
    output logic [CNT_W-1:0] pkt_count
);

    // state   | meaning
    // COLLECT | shifting accepted bytes into acc
    // HOLD    | word_out presented, waiting for downstream handshake
    // DRAIN   | oversize packet, discarding bytes until end_in
    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        HOLD    = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [23:0] acc, acc_nx;
    logic [2:0]  byte_cnt, cnt_nx;
    logic [2:0]  byte_total;
    logic [31:0] word_nx;
    logic        wvalid_nx;
    logic        err_nx;
    logic        pkt_inc;
    logic        accept;

    assign accept     = valid_in && ready_in;
    assign byte_total = (byte_cnt == 3'd7) ? 3'd7 : byte_cnt + 3'd1;

    always_comb begin
        state_nx  = state;
        acc_nx    = acc;
        cnt_nx    = byte_cnt;
        word_nx   = word_out;
        wvalid_nx = word_valid;
        err_nx    = 1'b0;
        pkt_inc   = 1'b0;
        case (state)
            COLLECT: begin
                if (accept) begin
                    if (end_in) begin
                        acc_nx = '0;
                        cnt_nx = '0;
`ifdef AVST_WORD_SINK_LEN_CHECK_EN
                        if (byte_total == 3'd4) begin
                            word_nx   = {acc, data_in};
                            wvalid_nx = 1'b1;
                            state_nx  = HOLD;
                        end else begin
                            err_nx = 1'b1;
                        end
`else
                        // Short packets come out zero-extended, long ones keep the last 4 bytes.
                        word_nx   = {acc, data_in};
                        wvalid_nx = 1'b1;
                        state_nx  = HOLD;
`endif
                    end else begin
`ifdef AVST_WORD_SINK_LEN_CHECK_EN
                        if (byte_total == 3'd5) begin
                            err_nx   = 1'b1;
                            acc_nx   = '0;
                            cnt_nx   = '0;
                            state_nx = DRAIN;
                        end else begin
                            acc_nx = {acc[15:0], data_in};
                            cnt_nx = byte_total;
                        end
`else
                        acc_nx = {acc[15:0], data_in};
                        cnt_nx = byte_total;
`endif
                    end
                end
            end
            HOLD: begin
                if (word_ready) begin
                    wvalid_nx = 1'b0;
                    pkt_inc   = 1'b1;
                    state_nx  = COLLECT;
                end
            end
            DRAIN: begin
                if (accept && end_in) begin
                    state_nx = COLLECT;
                end
            end
            default: begin
                state_nx = COLLECT;
            end
        endcase
    end

    // ready_in is registered from the next state so it never sees word_ready combinationally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= COLLECT;
            acc        <= '0;
            byte_cnt   <= '0;
            ready_in   <= 1'b1;
            word_out   <= '0;
            word_valid <= 1'b0;
            len_err    <= 1'b0;
            pkt_count  <= '0;
        end else begin
            state      <= state_nx;
            acc        <= acc_nx;
            byte_cnt   <= cnt_nx;
            ready_in   <= (state_nx != HOLD);
            word_out   <= word_nx;
            word_valid <= wvalid_nx;
            len_err    <= err_nx;
            if (pkt_inc) begin
                pkt_count <= pkt_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_avst_word_sink.sv
// Directed, table-driven bench for avst_word_sink; expectations follow the
// AVST_WORD_SINK_LEN_CHECK_EN setting of the build.
module tb_avst_word_sink;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  data_in;
    logic        end_in;
    logic        valid_in;
    logic        ready_in;
    logic [31:0] word_out;
    logic        word_valid;
    logic        word_ready;
    logic        len_err;
    logic [15:0] pkt_count;

    int vec_cnt  = 0;
    int fail_cnt = 0;
    logic [15:0] pkt_exp = '0;

    avst_word_sink #(.CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .end_in     (end_in),
        .valid_in   (valid_in),
        .ready_in   (ready_in),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .len_err    (len_err),
        .pkt_count  (pkt_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          len;
        logic [63:0] bytes;
        int          gap;
        int          hold;
        bit          exp_valid;
        logic [31:0] exp_word;
        int          err_at;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic e);
        int n;
        valid_in = 1'b1;
        data_in  = d;
        end_in   = e;
        n = 0;
        while (!ready_in && n < 20) begin
            tick();
            n++;
        end
        if (!ready_in) check("ready_timeout", {31'd0, ready_in}, 32'd1);
        tick();
        valid_in = 1'b0;
        end_in   = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, {31'd0, ready_in}, 32'd1);
        check({tag, "_wvalid"}, {31'd0, word_valid}, 32'd0);
        check({tag, "_word"}, word_out, 32'd0);
        check({tag, "_lenerr"}, {31'd0, len_err}, 32'd0);
        check({tag, "_pktcnt"}, {16'd0, pkt_count}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        word_ready = (v.hold == 0);
        for (int i = 0; i < v.len; i++) begin
            send_byte(v.bytes[63 - 8*i -: 8], (i == v.len - 1));
            check({tag, "_lenerr"}, {31'd0, len_err}, {31'd0, (i == v.err_at)});
            if (i != v.len - 1) begin
                for (int g = 0; g < v.gap; g++) tick();
            end
        end
        check({tag, "_wvalid"}, {31'd0, word_valid}, {31'd0, v.exp_valid});
        if (v.exp_valid) begin
            check({tag, "_word"}, word_out, v.exp_word);
            check({tag, "_ready_hold"}, {31'd0, ready_in}, 32'd0);
            for (int d = 0; d < v.hold; d++) begin
                tick();
                check({tag, "_held_valid"}, {31'd0, word_valid}, 32'd1);
                check({tag, "_held_word"}, word_out, v.exp_word);
                check({tag, "_held_ready"}, {31'd0, ready_in}, 32'd0);
            end
            word_ready = 1'b1;
            tick();
            pkt_exp++;
            check({tag, "_post_valid"}, {31'd0, word_valid}, 32'd0);
            check({tag, "_post_ready"}, {31'd0, ready_in}, 32'd1);
            check({tag, "_pktcnt"}, {16'd0, pkt_count}, {16'd0, pkt_exp});
            check({tag, "_word_kept"}, word_out, v.exp_word);
        end else begin
            tick();
            check({tag, "_lenerr_pulse"}, {31'd0, len_err}, 32'd0);
            check({tag, "_no_word"}, {31'd0, word_valid}, 32'd0);
            check({tag, "_pktcnt"}, {16'd0, pkt_count}, {16'd0, pkt_exp});
        end
        word_ready = 1'b0;
        tick();
    endtask

    initial begin
        vecs[0] = '{4, 64'h0000_012C_0000_0000, 0, 0, 1'b1, 32'h0000_012C, -1};
        vecs[1] = '{4, 64'h0000_012C_0000_0000, 0, 5, 1'b1, 32'h0000_012C, -1};
`ifdef AVST_WORD_SINK_LEN_CHECK_EN
        vecs[2] = '{2, 64'hABCD_0000_0000_0000, 0, 0, 1'b0, 32'h0, 1};
        vecs[3] = '{6, 64'h1122_3344_5566_0000, 0, 0, 1'b0, 32'h0, 4};
        vecs[6] = '{1, 64'h5A00_0000_0000_0000, 0, 0, 1'b0, 32'h0, 0};
`else
        vecs[2] = '{2, 64'hABCD_0000_0000_0000, 0, 0, 1'b1, 32'h0000_ABCD, -1};
        vecs[3] = '{6, 64'h1122_3344_5566_0000, 0, 0, 1'b1, 32'h3344_5566, -1};
        vecs[6] = '{1, 64'h5A00_0000_0000_0000, 0, 0, 1'b1, 32'h0000_005A, -1};
`endif
        vecs[4] = '{4, 64'hDEAD_BEEF_0000_0000, 1, 0, 1'b1, 32'hDEAD_BEEF, -1};
        vecs[5] = '{4, 64'hDEAD_BEEF_0000_0000, 3, 2, 1'b1, 32'hDEAD_BEEF, -1};
        vecs[7] = '{4, 64'h1234_5678_0000_0000, 2, 1, 1'b1, 32'h1234_5678, -1};

        reset      = 1'b1;
        data_in    = 8'h00;
        end_in     = 1'b0;
        valid_in   = 1'b0;
        word_ready = 1'b0;
        #1;
        check_reset_values("rst0");
        tick();
        tick();
        reset = 1'b0;
        tick();

        for (int k = 0; k < 8; k++) run_vec(vecs[k], k);

        // Reset mid-packet: two bytes in, reset between edges, then a clean packet.
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("rst_mid");
        tick();
        reset = 1'b0;
        pkt_exp = '0;
        tick();
        run_vec(vecs[4], 10);

        // Reset while a word is held.
        word_ready = 1'b0;
        send_byte(8'hCA, 1'b0);
        send_byte(8'hFE, 1'b0);
        send_byte(8'hBA, 1'b0);
        send_byte(8'hBE, 1'b1);
        check("hold_before_rst", {31'd0, word_valid}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("rst_hold");
        tick();
        reset = 1'b0;
        pkt_exp = '0;
        tick();
        run_vec(vecs[7], 11);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
        $finish;
    end

endmodule
